// File: rtl/wb_pkg.sv
// Shared defaults and state encoding for the MEM/WB writeback stage of the 16-bit core.
package wb_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_AW   = 3;
  localparam int LINK_REG = 7;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    WB_RUN,
    WB_DUMP,
    WB_HALTED
  } wb_state_t;

endpackage

// File: rtl/wb_bypass.sv
// Same-cycle bypass detection: flags decode read ports that match the register being written this cycle.
module wb_bypass #(
  parameter int REG_AW = 3
) (
  input  logic              write_en,
  input  logic [REG_AW-1:0] write_reg,
  input  logic [REG_AW-1:0] read1_sel,
  input  logic [REG_AW-1:0] read2_sel,
  output logic              hit1,
  output logic              hit2
);

  // R0 is an ordinary register here, so no zero-register exclusion.
  assign hit1 = write_en && (write_reg == read1_sel);
  assign hit2 = write_en && (write_reg == read2_sel);

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, register-file write port, halt/dump sequencing and retire counter.
module writeback_stage #(
  parameter int DATA_W   = wb_pkg::DATA_W,
  parameter int REG_AW   = wb_pkg::REG_AW,
  parameter int LINK_REG = wb_pkg::LINK_REG,
  parameter int CNT_W    = wb_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memValid,
  input  logic [DATA_W-1:0] memAluResult,
  input  logic [DATA_W-1:0] memReadData,
  input  logic [DATA_W-1:0] memPcPlus2,
  input  logic [REG_AW-1:0] memWriteReg,
  input  logic              memRegWrite,
  input  logic              memMemToReg,
  input  logic              memLink,
  input  logic              memHalt,
  input  logic              wbStall,
  input  logic              wbFlush,
  input  logic [REG_AW-1:0] readReg1Sel,
  input  logic [REG_AW-1:0] readReg2Sel,
  output logic [DATA_W-1:0] writeData,
  output logic [REG_AW-1:0] writeRegister,
  output logic              writeEn,
  output logic              bypass1Hit,
  output logic              bypass2Hit,
  output logic              dump,
  output logic              halted,
  output logic [CNT_W-1:0]  retireCount
);

  import wb_pkg::*;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] pc_plus2;
    logic [REG_AW-1:0] write_reg;
    logic              reg_write;
    logic              mem_to_reg;
    logic              link;
    logic              halt;
  } memwb_t;

  memwb_t            memwb_q;
  wb_state_t         state_q, state_d;
  logic [CNT_W-1:0]  retire_q;
  logic              in_run;
  logic [DATA_W-1:0] sel_data;
  logic [REG_AW-1:0] sel_reg;
  logic              write_en;

  assign in_run = (state_q == WB_RUN);

  // NOTE: every flop uses non-blocking assignment and the async reset clears all state at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memwb_q <= '0;
    end else if (state_q != WB_HALTED) begin
      if (wbFlush) begin
        memwb_q.valid <= 1'b0;
      end else if (!wbStall) begin
        memwb_q <= '{valid:      memValid,
                     alu_result: memAluResult,
                     read_data:  memReadData,
                     pc_plus2:   memPcPlus2,
                     write_reg:  memWriteReg,
                     reg_write:  memRegWrite,
                     mem_to_reg: memMemToReg,
                     link:       memLink,
                     halt:       memHalt};
      end
    end
  end

  // NOTE: defaults first so no path through the block leaves a signal unassigned (no latches).
  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_RUN:    if (memwb_q.valid && memwb_q.halt && !wbStall) state_d = WB_DUMP;
      WB_DUMP:   state_d = WB_HALTED;
      WB_HALTED: state_d = WB_HALTED;
      default:   state_d = WB_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= WB_RUN;
    else      state_q <= state_d;
  end

  assign dump   = (state_q == WB_DUMP);
  assign halted = !in_run;

  // Link overrides both the destination and the data source.
  always_comb begin
    sel_data = memwb_q.alu_result;
    sel_reg  = memwb_q.write_reg;
    if (memwb_q.link) begin
      sel_data = memwb_q.pc_plus2;
      sel_reg  = REG_AW'(LINK_REG);
    end else if (memwb_q.mem_to_reg) begin
      sel_data = memwb_q.read_data;
    end
  end

  assign write_en      = memwb_q.valid && (memwb_q.reg_write || memwb_q.link) && !memwb_q.halt && in_run;
  assign writeEn       = write_en;
  assign writeData     = write_en ? sel_data : '0;
  assign writeRegister = write_en ? sel_reg  : '0;

  // A stalled instruction is counted only on the cycle it finally leaves the register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_q <= '0;
    end else if (memwb_q.valid && !wbStall && in_run && (retire_q != '1)) begin
      retire_q <= retire_q + 1'b1;
    end
  end

  assign retireCount = retire_q;

  wb_bypass #(.REG_AW(REG_AW)) u_bypass (
    .write_en  (write_en),
    .write_reg (writeRegister),
    .read1_sel (readReg1Sel),
    .read2_sel (readReg2Sel),
    .hit1      (bypass1Hit),
    .hit2      (bypass2Hit)
  );

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: reset, write-data selection, stall/flush, halt/dump and reset-in-dump.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        memValid;
  logic [15:0] memAluResult, memReadData, memPcPlus2;
  logic [2:0]  memWriteReg;
  logic        memRegWrite, memMemToReg, memLink, memHalt;
  logic        wbStall, wbFlush;
  logic [2:0]  readReg1Sel, readReg2Sel;
  logic [15:0] writeData;
  logic [2:0]  writeRegister;
  logic        writeEn, bypass1Hit, bypass2Hit, dump, halted;
  logic [15:0] retireCount;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk           (clk),
    .rst           (rst),
    .memValid      (memValid),
    .memAluResult  (memAluResult),
    .memReadData   (memReadData),
    .memPcPlus2    (memPcPlus2),
    .memWriteReg   (memWriteReg),
    .memRegWrite   (memRegWrite),
    .memMemToReg   (memMemToReg),
    .memLink       (memLink),
    .memHalt       (memHalt),
    .wbStall       (wbStall),
    .wbFlush       (wbFlush),
    .readReg1Sel   (readReg1Sel),
    .readReg2Sel   (readReg2Sel),
    .writeData     (writeData),
    .writeRegister (writeRegister),
    .writeEn       (writeEn),
    .bypass1Hit    (bypass1Hit),
    .bypass2Hit    (bypass2Hit),
    .dump          (dump),
    .halted        (halted),
    .retireCount   (retireCount)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    memValid = 0; memAluResult = '0; memReadData = '0; memPcPlus2 = '0;
    memWriteReg = '0; memRegWrite = 0; memMemToReg = 0; memLink = 0; memHalt = 0;
    wbStall = 0; wbFlush = 0; readReg1Sel = '0; readReg2Sel = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    step();
    step();
    rst = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    #3;
    n_checks++;
    if ({writeEn, dump, halted, bypass1Hit, bypass2Hit} !== 5'b0 || writeData !== 16'h0 ||
        writeRegister !== 3'd0 || retireCount !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: we=%b dump=%b halted=%b wd=%h wr=%0d cnt=%0d, required all 0",
               writeEn, dump, halted, writeData, writeRegister, retireCount);
    end
    step();
    rst = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (writeEn !== 0 || dump !== 0 || halted !== 0 || retireCount !== 16'd0) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: we=%b dump=%b halted=%b cnt=%0d, required 0 0 0 0",
                 i, writeEn, dump, halted, retireCount);
      end
    end
  endtask

  task automatic test_alu_write();
    memValid = 1; memAluResult = 16'h1234; memWriteReg = 3'd3; memRegWrite = 1;
    readReg1Sel = 3'd3; readReg2Sel = 3'd5;
    step();
    n_checks++;
    if (writeEn !== 1 || writeRegister !== 3'd3 || writeData !== 16'h1234) begin
      n_fail++;
      $display("FAIL alu_write: we=%b wr=%0d wd=%h, required 1 3 1234", writeEn, writeRegister, writeData);
    end
    n_checks++;
    if (bypass1Hit !== 1 || bypass2Hit !== 0) begin
      n_fail++;
      $display("FAIL alu_bypass: hit1=%b hit2=%b, required 1 0", bypass1Hit, bypass2Hit);
    end
    n_checks++;
    if (retireCount !== 16'd0) begin
      n_fail++;
      $display("FAIL alu_count: cnt=%0d, required 0", retireCount);
    end
  endtask

  task automatic test_load_and_link();
    memMemToReg = 1; memReadData = 16'hBEEF; memAluResult = 16'h0010; memWriteReg = 3'd4;
    step();
    n_checks++;
    if (writeEn !== 1 || writeData !== 16'hBEEF || writeRegister !== 3'd4 || retireCount !== 16'd1) begin
      n_fail++;
      $display("FAIL load_write: we=%b wd=%h wr=%0d cnt=%0d, required 1 beef 4 1",
               writeEn, writeData, writeRegister, retireCount);
    end
    memLink = 1; memPcPlus2 = 16'h0042; memWriteReg = 3'd2; readReg1Sel = 3'd7;
    step();
    n_checks++;
    if (writeEn !== 1 || writeRegister !== 3'd7 || writeData !== 16'h0042 || bypass1Hit !== 1) begin
      n_fail++;
      $display("FAIL link_write: we=%b wr=%0d wd=%h hit1=%b, required 1 7 0042 1",
               writeEn, writeRegister, writeData, bypass1Hit);
    end
    memLink = 0; memMemToReg = 0; memAluResult = 16'h5555; memWriteReg = 3'd0; readReg2Sel = 3'd0;
    step();
    n_checks++;
    if (writeRegister !== 3'd0 || writeData !== 16'h5555 || bypass2Hit !== 1 || retireCount !== 16'd3) begin
      n_fail++;
      $display("FAIL r0_bypass: wr=%0d wd=%h hit2=%b cnt=%0d, required 0 5555 1 3",
               writeRegister, writeData, bypass2Hit, retireCount);
    end
    memRegWrite = 0;
    step();
    n_checks++;
    if (writeEn !== 0 || writeData !== 16'h0 || bypass2Hit !== 0 || retireCount !== 16'd4) begin
      n_fail++;
      $display("FAIL no_write: we=%b wd=%h hit2=%b cnt=%0d, required 0 0000 0 4",
               writeEn, writeData, bypass2Hit, retireCount);
    end
  endtask

  task automatic test_stall_flush();
    memValid = 1; memRegWrite = 1; memAluResult = 16'hAAAA; memWriteReg = 3'd1;
    readReg1Sel = 3'd0; readReg2Sel = 3'd0;
    step();
    n_checks++;
    if (writeData !== 16'hAAAA || writeRegister !== 3'd1 || retireCount !== 16'd5) begin
      n_fail++;
      $display("FAIL pre_stall: wd=%h wr=%0d cnt=%0d, required aaaa 1 5", writeData, writeRegister, retireCount);
    end
    wbStall = 1; memAluResult = 16'hBBBB; memWriteReg = 3'd6;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (writeEn !== 1 || writeData !== 16'hAAAA || writeRegister !== 3'd1 || retireCount !== 16'd5) begin
        n_fail++;
        $display("FAIL stall_hold%0d: we=%b wd=%h wr=%0d cnt=%0d, required 1 aaaa 1 5",
                 i, writeEn, writeData, writeRegister, retireCount);
      end
    end
    wbStall = 0;
    step();
    n_checks++;
    if (writeData !== 16'hBBBB || writeRegister !== 3'd6 || retireCount !== 16'd6) begin
      n_fail++;
      $display("FAIL stall_release: wd=%h wr=%0d cnt=%0d, required bbbb 6 6", writeData, writeRegister, retireCount);
    end
    wbStall = 1; wbFlush = 1; memAluResult = 16'hCCCC; memWriteReg = 3'd2;
    step();
    n_checks++;
    if (writeEn !== 0 || writeData !== 16'h0 || writeRegister !== 3'd0 || retireCount !== 16'd6) begin
      n_fail++;
      $display("FAIL stall_flush: we=%b wd=%h wr=%0d cnt=%0d, required 0 0000 0 6",
               writeEn, writeData, writeRegister, retireCount);
    end
    wbStall = 0; wbFlush = 0; memValid = 0;
    step();
    n_checks++;
    if (writeEn !== 0 || retireCount !== 16'd6) begin
      n_fail++;
      $display("FAIL bubble_count: we=%b cnt=%0d, required 0 6", writeEn, retireCount);
    end
  endtask

  task automatic test_halt();
    memValid = 1; memHalt = 1; memRegWrite = 1; memWriteReg = 3'd5; memAluResult = 16'h7777;
    step();
    n_checks++;
    if (writeEn !== 0 || dump !== 0 || halted !== 0) begin
      n_fail++;
      $display("FAIL halt_latched: we=%b dump=%b halted=%b, required 0 0 0", writeEn, dump, halted);
    end
    memHalt = 0; memAluResult = 16'h9999; wbStall = 1;
    step();
    n_checks++;
    if (dump !== 0 || halted !== 0 || retireCount !== 16'd6) begin
      n_fail++;
      $display("FAIL halt_stalled: dump=%b halted=%b cnt=%0d, required 0 0 6", dump, halted, retireCount);
    end
    wbStall = 0;
    step();
    n_checks++;
    if (dump !== 1 || halted !== 1 || writeEn !== 0 || retireCount !== 16'd7) begin
      n_fail++;
      $display("FAIL dump_pulse: dump=%b halted=%b we=%b cnt=%0d, required 1 1 0 7",
               dump, halted, writeEn, retireCount);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (dump !== 0 || halted !== 1 || writeEn !== 0 || writeData !== 16'h0 || retireCount !== 16'd7) begin
        n_fail++;
        $display("FAIL halted_cycle%0d: dump=%b halted=%b we=%b wd=%h cnt=%0d, required 0 1 0 0000 7",
                 i, dump, halted, writeEn, writeData, retireCount);
      end
    end
  endtask

  task automatic test_reset_in_dump();
    do_reset();
    memValid = 1; memHalt = 1;
    step();
    memValid = 0; memHalt = 0;
    step();
    n_checks++;
    if (dump !== 1 || retireCount !== 16'd1) begin
      n_fail++;
      $display("FAIL dump_before_reset: dump=%b cnt=%0d, required 1 1", dump, retireCount);
    end
    #2 rst = 0;
    #1;
    n_checks++;
    if (dump !== 0 || halted !== 0 || writeEn !== 0 || retireCount !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset_dump: dump=%b halted=%b we=%b cnt=%0d, required 0 0 0 0",
               dump, halted, writeEn, retireCount);
    end
    step();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (dump !== 0 || halted !== 0 || retireCount !== 16'd0) begin
        n_fail++;
        $display("FAIL post_reset%0d: dump=%b halted=%b cnt=%0d, required 0 0 0", i, dump, halted, retireCount);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_load_and_link();
    test_stall_flush();
    test_halt();
    test_reset_in_dump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
